// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage.
// Produces {remainder, quotient} for HI/LO and stalls the pipeline while busy.
`timescale 1ns/1ps
`ifndef DIV_CONTROL
`define DIV_CONTROL  5'b11010
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL 5'b11011
`endif

module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           alucontrol,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 stall_div
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 sa_q, sa_d, sb_q, sb_d, sgn_q, sgn_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic                 is_signed, start;
    logic [WIDTH:0]       shifted;
    logic [WIDTH+1:0]     diff;
    logic                 borrow;
    logic [WIDTH-1:0]     step_rem, step_quo, fix_rem, fix_quo;

    assign is_signed = (alucontrol == `DIV_CONTROL);
    assign start     = (is_signed || alucontrol == `DIVU_CONTROL) && !annul;

    // One restoring step: bring down the next dividend bit, trial-subtract the divisor.
    assign shifted  = {rem_q, dvd_q[WIDTH-1]};
    assign diff     = {1'b0, shifted} - {2'b00, dvs_q};
    assign borrow   = diff[WIDTH+1];
    assign step_rem = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign step_quo = {dvd_q[WIDTH-2:0], ~borrow};
    assign fix_quo  = (sgn_q && (sa_q ^ sb_q)) ? (~step_quo + 1'b1) : step_quo;
    assign fix_rem  = (sgn_q && sa_q) ? (~step_rem + 1'b1) : step_rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        sgn_d     = sgn_q;
        result_d  = result_q;
        ready_d   = 1'b0;
        stall_div = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stall_div = 1'b1;
                    sgn_d     = is_signed;
                    sa_d      = opdata1[WIDTH-1];
                    sb_d      = opdata2[WIDTH-1];
                    cnt_d     = '0;
                    rem_d     = '0;
                    if (opdata2 == '0) begin
                        state_d = S_DIVZERO;
                        dvd_d   = opdata1;
                    end else begin
                        state_d = S_ON;
                        dvd_d   = (is_signed && opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
                        dvs_d   = (is_signed && opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;
                    end
                end
            end
            S_DIVZERO: begin
                stall_div = 1'b1;
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_END;
                    result_d = {dvd_q, {WIDTH{1'b1}}};
                    ready_d  = 1'b1;
                end
            end
            S_ON: begin
                stall_div = 1'b1;
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = step_rem;
                    dvd_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = S_END;
                        result_d = {fix_rem, fix_quo};
                        ready_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            sgn_q    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sgn_q    <= sgn_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule
